pwm_seq_ctrl: RTL and testbench

PWM_SEQ_CTRL -- requirements
Module: pwm_seq_ctrl

---
 rtl/pwm_seq_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_pwm_seq_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_seq_ctrl
// Brightness-envelope sequencer. Walks the duty command of a PWM LED generator
// through ramp-up / hold-high / ramp-down / hold-low loops, advancing at most
// once per PWM period (period_tick).
//
// Ports
//   CLK          system clock, single domain
//   RST          synchronous active-high reset
//   start        one-cycle request to begin a sequence (ignored while busy)
//   stop         abort request, returns to IDLE with duty 0
//   period_tick  strobe marking the end of each PWM period
//   step         duty increment/decrement per tick (0 behaves as 1)
//   max_duty     ramp-up ceiling
//   hold_hi      extra ticks spent at max_duty
//   hold_lo      extra ticks spent at zero
//   loops        number of full cycles, 0 = run forever
//   duty         registered duty command
//   duty_upd     pulses in every cycle where duty differs from the previous one
//   busy         high whenever not IDLE
//   done         one-cycle pulse when the programmed loop count completes
// -----------------------------------------------------------------------------
module pwm_seq_ctrl #(
  parameter int DUTY_W = 8,
  parameter int HOLD_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              stop,
  input  logic              period_tick,
  input  logic [DUTY_W-1:0] step,
  input  logic [DUTY_W-1:0] max_duty,
  input  logic [HOLD_W-1:0] hold_hi,
  input  logic [HOLD_W-1:0] hold_lo,
  input  logic [7:0]        loops,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_upd,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UP     = 3'd1;
  localparam logic [2:0] S_HOLD_H = 3'd2;
  localparam logic [2:0] S_DOWN   = 3'd3;
  localparam logic [2:0] S_HOLD_L = 3'd4;

  localparam logic [DUTY_W-1:0] DUTY_ZERO = {DUTY_W{1'b0}};
  localparam logic [DUTY_W-1:0] DUTY_ONE  = {{(DUTY_W-1){1'b0}}, 1'b1};
  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};

  logic [2:0]        state_r, state_s;
  logic [DUTY_W-1:0] duty_r, duty_s;
  logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_s;
  logic [7:0]        loop_cnt_r, loop_cnt_s;
  logic [DUTY_W-1:0] step_cfg_r, max_cfg_r;
  logic [HOLD_W-1:0] hold_hi_cfg_r, hold_lo_cfg_r;
  logic [7:0]        loops_cfg_r;
  logic              duty_upd_r, busy_r, done_r;
  logic              cap_s, done_s;
  logic [DUTY_W:0]   up_sum_s;
  logic [7:0]        loop_inc_s;

  // Ramp-up sum is one bit wider so the ceiling compare never sees a wrap.
  assign up_sum_s   = {1'b0, duty_r} + {1'b0, step_cfg_r};
  assign loop_inc_s = loop_cnt_r + 8'd1;

  // Next-state, next-duty and counter logic for the envelope FSM.
  always_comb begin
    state_s    = state_r;
    duty_s     = duty_r;
    hold_cnt_s = hold_cnt_r;
    loop_cnt_s = loop_cnt_r;
    cap_s      = 1'b0;
    done_s     = 1'b0;
    if (state_r == S_IDLE) begin
      // stop outranks start so a simultaneous pair leaves the block idle
      if (start && !stop) begin
        cap_s      = 1'b1;
        loop_cnt_s = 8'd0;
        hold_cnt_s = HOLD_ZERO;
        duty_s     = DUTY_ZERO;
        state_s    = S_UP;
      end else begin
        state_s = S_IDLE;
      end
    end else if (stop) begin
      state_s    = S_IDLE;
      duty_s     = DUTY_ZERO;
      hold_cnt_s = HOLD_ZERO;
      loop_cnt_s = 8'd0;
    end else if (period_tick) begin
      case (state_r)
        S_UP: begin
          if (up_sum_s >= {1'b0, max_cfg_r}) begin
            duty_s     = max_cfg_r;
            hold_cnt_s = HOLD_ZERO;
            state_s    = S_HOLD_H;
          end else begin
            duty_s = up_sum_s[DUTY_W-1:0];
          end
        end
        S_HOLD_H: begin
          if (hold_cnt_r >= hold_hi_cfg_r) begin
            state_s = S_DOWN;
          end else begin
            hold_cnt_s = hold_cnt_r + HOLD_ONE;
          end
        end
        S_DOWN: begin
          if (duty_r <= step_cfg_r) begin
            duty_s     = DUTY_ZERO;
            hold_cnt_s = HOLD_ZERO;
            state_s    = S_HOLD_L;
          end else begin
            duty_s = duty_r - step_cfg_r;
          end
        end
        S_HOLD_L: begin
          if (hold_cnt_r >= hold_lo_cfg_r) begin
            loop_cnt_s = loop_inc_s;
            // loops == 0 lets the counter wrap and never terminates
            if ((loops_cfg_r != 8'd0) && (loop_inc_s == loops_cfg_r)) begin
              state_s = S_IDLE;
              done_s  = 1'b1;
            end else begin
              state_s = S_UP;
            end
          end else begin
            hold_cnt_s = hold_cnt_r + HOLD_ONE;
          end
        end
        default: begin
          state_s = S_IDLE;
          duty_s  = DUTY_ZERO;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State, counters, captured configuration and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r       <= S_IDLE;
      duty_r        <= DUTY_ZERO;
      hold_cnt_r    <= HOLD_ZERO;
      loop_cnt_r    <= 8'd0;
      step_cfg_r    <= DUTY_ONE;
      max_cfg_r     <= DUTY_ZERO;
      hold_hi_cfg_r <= HOLD_ZERO;
      hold_lo_cfg_r <= HOLD_ZERO;
      loops_cfg_r   <= 8'd0;
      duty_upd_r    <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r    <= state_s;
      duty_r     <= duty_s;
      hold_cnt_r <= hold_cnt_s;
      loop_cnt_r <= loop_cnt_s;
      if (cap_s) begin
        // a zero step would stall the ramp forever, so it runs as 1
        step_cfg_r    <= (step == DUTY_ZERO) ? DUTY_ONE : step;
        max_cfg_r     <= max_duty;
        hold_hi_cfg_r <= hold_hi;
        hold_lo_cfg_r <= hold_lo;
        loops_cfg_r   <= loops;
      end else begin
        step_cfg_r    <= step_cfg_r;
        max_cfg_r     <= max_cfg_r;
        hold_hi_cfg_r <= hold_hi_cfg_r;
        hold_lo_cfg_r <= hold_lo_cfg_r;
        loops_cfg_r   <= loops_cfg_r;
      end
      duty_upd_r <= (duty_s != duty_r);
      busy_r     <= (state_s != S_IDLE);
      done_r     <= done_s;
    end
  end

  assign duty     = duty_r;
  assign duty_upd = duty_upd_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pwm_seq_ctrl
// Self-checking bench. The reference model expands each captured configuration
// into the list of duty values one loop produces (one entry per tick) and pops
// one entry per tick; every cycle the DUT outputs are compared with it.
// Directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_pwm_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RST, start, stop, period_tick;
  logic [7:0] step, max_duty, hold_hi, hold_lo, loops;
  logic [7:0] duty;
  logic       duty_upd, busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  pwm_seq_ctrl #(.DUTY_W(8), .HOLD_W(8)) dut (
    .CLK(CLK), .RST(RST), .start(start), .stop(stop),
    .period_tick(period_tick), .step(step), .max_duty(max_duty),
    .hold_hi(hold_hi), .hold_lo(hold_lo), .loops(loops),
    .duty(duty), .duty_upd(duty_upd), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int q[$];
  bit m_busy = 1'b0;
  int m_duty = 0;
  bit m_upd  = 1'b0;
  bit m_done = 1'b0;
  bit armed  = 1'b0;
  int c_step, c_max, c_hhi, c_hlo, c_loops, m_left;

  // Duty values seen after each tick of one full up/hold/down/hold loop.
  function automatic void build_loop();
    int d;
    d = 0;
    do begin
      d = (d + c_step >= c_max) ? c_max : d + c_step;
      q.push_back(d);
    end while (d != c_max);
    for (int i = 0; i <= c_hhi; i++) q.push_back(c_max);
    do begin
      d = (d <= c_step) ? 0 : d - c_step;
      q.push_back(d);
    end while (d != 0);
    for (int i = 0; i <= c_hlo; i++) q.push_back(0);
  endfunction

  initial begin
    int prev;
    forever begin
      @(posedge CLK);
      prev   = m_duty;
      m_done = 1'b0;
      if (RST) begin
        m_busy = 1'b0;
        m_duty = 0;
        m_upd  = 1'b0;
        q.delete();
        armed  = 1'b1;
      end else begin
        if (!m_busy) begin
          if (start && !stop) begin
            c_step  = (step == 8'd0) ? 1 : int'(step);
            c_max   = int'(max_duty);
            c_hhi   = int'(hold_hi);
            c_hlo   = int'(hold_lo);
            c_loops = int'(loops);
            m_left  = c_loops;
            q.delete();
            build_loop();
            m_busy  = 1'b1;
          end
        end else if (stop) begin
          m_busy = 1'b0;
          m_duty = 0;
          q.delete();
        end else if (period_tick) begin
          m_duty = q.pop_front();
          if (q.size() == 0) begin
            if (c_loops == 0) begin
              build_loop();
            end else begin
              m_left--;
              if (m_left == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
              end else begin
                build_loop();
              end
            end
          end
        end
        m_upd = (m_duty != prev);
      end
      #1;
      if (armed) begin
        chk("duty", int'(duty), m_duty);
        chk("duty_upd", int'(duty_upd), int'(m_upd));
        chk("busy", int'(busy), int'(m_busy));
        chk("done", int'(done), int'(m_done));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic t);
    period_tick = t;
    @(negedge CLK);
    period_tick = 1'b0;
  endtask

  task automatic start_seq(input int s, input int m, input int hh, input int hl, input int l);
    step = 8'(s); max_duty = 8'(m); hold_hi = 8'(hh); hold_lo = 8'(hl); loops = 8'(l);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  int exp32[13] = '{64, 128, 192, 200, 200, 200, 200, 136, 72, 8, 0, 0, 0};
  int exp33[8]  = '{255, 255, 0, 0, 255, 255, 0, 0};
  int seen_done;

  initial begin
    RST = 1'b1; start = 1'b0; stop = 1'b0; period_tick = 1'b0;
    step = 8'd0; max_duty = 8'd0; hold_hi = 8'd0; hold_lo = 8'd0; loops = 8'd0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    chk("reset_duty", int'(duty), 0);
    chk("reset_busy", int'(busy), 0);

    // basic trajectory with one loop
    start_seq(64, 200, 2, 1, 1);
    chk("start_busy", int'(busy), 1);
    for (int i = 0; i < 13; i++) begin
      cyc(1'b1);
      chk("traj32_duty", int'(duty), exp32[i]);
    end
    chk("traj32_done", int'(done), 1);
    chk("traj32_busy", int'(busy), 0);
    cyc(1'b0);
    chk("traj32_done_pulse", int'(done), 0);

    // endless full-swing loop
    start_seq(255, 255, 0, 0, 0);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1);
      if (i < 8) chk("swing_duty", int'(duty), exp33[i]);
      seen_done += int'(done);
    end
    chk("swing_never_done", seen_done, 0);
    stop = 1'b1; cyc(1'b0); stop = 1'b0;

    // stop together with a tick while ramping at 128
    start_seq(64, 200, 2, 1, 1);
    cyc(1'b1);
    cyc(1'b1);
    chk("pre_stop_duty", int'(duty), 128);
    stop = 1'b1; cyc(1'b1); stop = 1'b0;
    chk("stop_duty", int'(duty), 0);
    chk("stop_busy", int'(busy), 0);
    chk("stop_upd", int'(duty_upd), 1);
    chk("stop_done", int'(done), 0);

    // start and stop together in idle
    stop = 1'b1; start = 1'b1; cyc(1'b0); stop = 1'b0; start = 1'b0;
    chk("startstop_idle", int'(busy), 0);

    // restart attempts and config churn while busy
    start_seq(64, 200, 1, 1, 1);
    cyc(1'b1);
    step = 8'd10; max_duty = 8'd50; hold_hi = 8'd7; loops = 8'd0;
    start = 1'b1; cyc(1'b1); start = 1'b0;
    chk("no_restart_duty", int'(duty), 128);
    for (int i = 0; i < 16; i++) cyc(1'b1);
    chk("no_restart_end", int'(busy), 0);

    // zero step behaves as one
    start_seq(0, 3, 0, 0, 1);
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b1);
      chk("step0_duty", int'(duty), i);
    end
    for (int i = 0; i < 8; i++) cyc(1'b1);

    // reset in the middle of the high hold
    start_seq(64, 200, 5, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1'b1);
    chk("pre_rst_duty", int'(duty), 200);
    RST = 1'b1; start = 1'b1; stop = 1'b1; cyc(1'b1);
    RST = 1'b0; start = 1'b0; stop = 1'b0;
    chk("rst_duty", int'(duty), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_upd", int'(duty_upd), 0);
    chk("rst_done", int'(done), 0);
    start_seq(64, 200, 5, 0, 1);
    cyc(1'b1);
    chk("fresh_duty", int'(duty), 64);
    stop = 1'b1; cyc(1'b0); stop = 1'b0;

    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        step     = 8'($urandom_range(0, 255));
        max_duty = 8'($urandom_range(0, 255));
        hold_hi  = 8'($urandom_range(0, 3));
        hold_lo  = 8'($urandom_range(0, 3));
        loops    = 8'($urandom_range(0, 3));
      end
      start = ($urandom_range(0, 19) == 0);
      stop  = ($urandom_range(0, 399) == 0);
      RST   = ($urandom_range(0, 2999) == 0);
      cyc(1'($urandom_range(0, 1)));
    end
    RST = 1'b0; start = 1'b0; stop = 1'b0;
    cyc(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
